// File: rtl/audio_mixer_sd.sv
// Time-multiplexed N-channel 1-bit audio mixer with per-channel gain registers,
// driving a first-order sigma-delta DAC bitstream.
module audio_mixer_sd #(
  parameter  int NCH = 4,
  parameter  int GW  = 4,
  localparam int SW  = GW + $clog2(NCH + 1)
) (
  input  logic           clk_sys,
  input  logic           RESET,
  input  logic           ce,
  input  logic [NCH-1:0] ch_in,
  input  logic [2:0]     addr,
  input  logic           we_n,
  input  logic [7:0]     idata,
  output logic [7:0]     odata,
  output logic           busy,
  output logic [SW-1:0]  sample,
  output logic           audio_out
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, SUM, LOAD} state_t;

  state_t           state_q, state_d;
  logic [NCH-1:0]   snap_q, snap_d;
  logic [SW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [GW-1:0]    gain_q [NCH];
  logic [GW-1:0]    gain_d [NCH];
  logic             mute_q, mute_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic [SW-1:0]    sample_q, sample_d;
  logic [SW-1:0]    sd_acc_q, sd_acc_d;
  logic             aout_q, aout_d;
  logic             ce_ovr;

  function automatic logic [SW-1:0] gain_ext(input logic [GW-1:0] g);
    return {{(SW-GW){1'b0}}, g};
  endfunction

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    gain_d   = gain_q;
    mute_d   = mute_q;
    ovr_d    = ovr_q;
    busy_d   = busy_q;
    sample_d = sample_q;
    ce_ovr   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ce) begin
          snap_d  = ch_in;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = SUM;
        end
      end
      SUM: begin
        ce_ovr = ce;
        if (snap_q[idx_q]) acc_d = acc_q + gain_ext(gain_q[idx_q]);
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) state_d = LOAD;
      end
      LOAD: begin
        ce_ovr   = ce;
        sample_d = mute_q ? '0 : acc_q;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Register writes land after the SUM read above, so a same-cycle write uses the old gain.
    if (!we_n) begin
      for (int i = 0; i < NCH; i++)
        if (addr == 3'(i)) gain_d[i] = idata[GW-1:0];
      if (addr == 3'd7) begin
        mute_d = idata[0];
        if (idata[7]) ovr_d = 1'b0;
      end
    end
    if (ce_ovr) ovr_d = 1'b1;

    {aout_d, sd_acc_d} = {1'b0, sd_acc_q} + {1'b0, sample_q};
  end

  always_comb begin
    odata = 8'h00;
    for (int i = 0; i < NCH; i++)
      if (addr == 3'(i)) odata[GW-1:0] = gain_q[i];
    if (addr == 3'd7) odata = {ovr_q, 5'b0, busy_q, mute_q};
  end

  always_ff @(posedge clk_sys) begin
    if (!RESET) begin
      state_q  <= IDLE;
      snap_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      for (int i = 0; i < NCH; i++) gain_q[i] <= '1;
      mute_q   <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
      sample_q <= '0;
      sd_acc_q <= '0;
      aout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      gain_q   <= gain_d;
      mute_q   <= mute_d;
      ovr_q    <= ovr_d;
      busy_q   <= busy_d;
      sample_q <= sample_d;
      sd_acc_q <= sd_acc_d;
      aout_q   <= aout_d;
    end
  end

  assign busy      = busy_q;
  assign sample    = sample_q;
  assign audio_out = aout_q;

endmodule
